// File: rtl/demux_reg_if.sv
// Bundle of the demux_reg stream ports: one input stream, two output streams
// and the per-output transfer counters. The slave modport is the demux side,
// the master modport is the environment (producer plus both consumers).
interface demux_reg_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     in_data;
    logic                 in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_data;
    logic                 a_valid;
    logic                 a_ready;
    logic [WIDTH-1:0]     b_data;
    logic                 b_valid;
    logic                 b_ready;
    logic [CNT_WIDTH-1:0] a_count;
    logic [CNT_WIDTH-1:0] b_count;

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer. in_sel=1 routes the input word to slot A,
// in_sel=0 to slot B. Each slot is a single-entry register with its own
// valid/ready handshake, so a stalled consumer never blocks the other one.
// A slot can load and drain in the same cycle, which gives one word per
// cycle per destination. Each output counts its completed handshakes.
module demux_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    demux_reg_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t          a_state, a_state_nxt;
    slot_state_t          b_state, b_state_nxt;
    logic [WIDTH-1:0]     a_data_q, b_data_q;
    logic [CNT_WIDTH-1:0] a_count_q, b_count_q;

    logic a_free, b_free;
    logic a_drain, b_drain;
    logic a_load, b_load;
    logic in_ready;
    logic in_fire;

    // Handshake decode and next state of both slots.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        a_state_nxt = a_state;
        b_state_nxt = b_state;
        a_drain     = (a_state == FULL) && bus.a_ready;
        b_drain     = (b_state == FULL) && bus.b_ready;
        a_free      = (a_state == EMPTY) || bus.a_ready;
        b_free      = (b_state == EMPTY) || bus.b_ready;
        in_ready    = bus.in_sel ? a_free : b_free;
        in_fire     = bus.in_valid && in_ready;
        a_load      = in_fire && bus.in_sel;
        b_load      = in_fire && !bus.in_sel;

        // A load wins over a drain so load+drain keeps the slot FULL.
        if (a_load) begin
            a_state_nxt = FULL;
        end else if (a_drain) begin
            a_state_nxt = EMPTY;
        end

        if (b_load) begin
            b_state_nxt = FULL;
        end else if (b_drain) begin
            b_state_nxt = EMPTY;
        end
    end

    // Slot state registers; reset discards any held word.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_state_nxt;
            b_state <= b_state_nxt;
        end
    end

    // Data holding registers; they only change on a load, so a drained
    // slot keeps showing its last word.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are reset too, so the outputs read a
        // defined zero after reset rather than whatever powered up.
        if (rst) begin
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            if (a_load) begin
                a_data_q <= bus.in_data;
            end
            if (b_load) begin
                b_data_q <= bus.in_data;
            end
        end
    end

    // Transfer counters, one per output, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            if (a_drain) begin
                a_count_q <= a_count_q + 1'b1;
            end
            if (b_drain) begin
                b_count_q <= b_count_q + 1'b1;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.a_data   = a_data_q;
    assign bus.a_valid  = (a_state == FULL);
    assign bus.b_data   = b_data_q;
    assign bus.b_valid  = (b_state == FULL);
    assign bus.a_count  = a_count_q;
    assign bus.b_count  = b_count_q;

endmodule

// File: tb/tb_demux_reg.sv
// Directed testbench for demux_reg. A 16-bit-counter instance covers reset,
// routing, back-pressure, streaming and mid-operation reset; a 4-bit-counter
// instance covers counter wrap. Inputs change 1ns after the rising edge and
// outputs are sampled there, away from the edge.
module tb_demux_reg;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    demux_reg_if #(.WIDTH(8), .CNT_WIDTH(16)) u_if ();
    demux_reg_if #(.WIDTH(8), .CNT_WIDTH(4))  w_if ();

    demux_reg #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    demux_reg #(.WIDTH(8), .CNT_WIDTH(4)) w_dut (
        .clk (clk),
        .rst (rst),
        .bus (w_if.slave)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run is a fixed number of cycles, so this never fires
    // unless simulation time runs away.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad_ready;
        int bad_data;

        // ---------------- reset with in_valid asserted ----------------
        rst           = 1'b1;
        u_if.in_data  = 8'h77;
        u_if.in_sel   = 1'b1;
        u_if.in_valid = 1'b1;
        u_if.a_ready  = 1'b1;
        u_if.b_ready  = 1'b1;
        w_if.in_data  = 8'h00;
        w_if.in_sel   = 1'b1;
        w_if.in_valid = 1'b0;
        w_if.a_ready  = 1'b1;
        w_if.b_ready  = 1'b1;
        step();
        step();
        check("rst_a_valid", 32'(u_if.a_valid), 32'd0);
        check("rst_b_valid", 32'(u_if.b_valid), 32'd0);
        check("rst_a_data",  32'(u_if.a_data),  32'h00);
        check("rst_b_data",  32'(u_if.b_data),  32'h00);
        check("rst_a_count", 32'(u_if.a_count), 32'd0);
        check("rst_b_count", 32'(u_if.b_count), 32'd0);
        rst           = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_sel   = 1'b1;
        #1;
        check("rst_in_ready_sel1", 32'(u_if.in_ready), 32'd1);
        u_if.in_sel = 1'b0;
        #1;
        check("rst_in_ready_sel0", 32'(u_if.in_ready), 32'd1);

        // ---------------- routing ----------------
        u_if.in_sel   = 1'b1;
        u_if.in_data  = 8'h3C;
        u_if.in_valid = 1'b1;
        step();
        check("route_a_valid", 32'(u_if.a_valid), 32'd1);
        check("route_a_data",  32'(u_if.a_data),  32'h3C);
        check("route_b_idle",  32'(u_if.b_valid), 32'd0);
        u_if.in_sel  = 1'b0;
        u_if.in_data = 8'hA5;
        step();
        check("route_b_valid", 32'(u_if.b_valid), 32'd1);
        check("route_b_data",  32'(u_if.b_data),  32'hA5);
        check("route_a_drained", 32'(u_if.a_valid), 32'd0);
        check("route_a_hold", 32'(u_if.a_data), 32'h3C);
        check("route_a_count", 32'(u_if.a_count), 32'd1);
        u_if.in_valid = 1'b0;
        step();
        check("route_b_drained", 32'(u_if.b_valid), 32'd0);
        check("route_b_count", 32'(u_if.b_count), 32'd1);

        // ---------------- back-pressure on A ----------------
        u_if.a_ready  = 1'b0;
        u_if.in_sel   = 1'b1;
        u_if.in_data  = 8'h11;
        u_if.in_valid = 1'b1;
        step();
        check("bp_a_valid", 32'(u_if.a_valid), 32'd1);
        check("bp_a_data",  32'(u_if.a_data),  32'h11);
        u_if.in_data = 8'h33;
        #1;
        check("bp_in_ready_a_full", 32'(u_if.in_ready), 32'd0);
        step();
        check("bp_a_data_held", 32'(u_if.a_data),  32'h11);
        check("bp_a_count_held", 32'(u_if.a_count), 32'd1);
        u_if.in_sel  = 1'b0;
        u_if.in_data = 8'h22;
        #1;
        check("bp_in_ready_b", 32'(u_if.in_ready), 32'd1);
        step();
        check("bp_b_valid", 32'(u_if.b_valid), 32'd1);
        check("bp_b_data",  32'(u_if.b_data),  32'h22);
        check("bp_a_still_held", 32'(u_if.a_data), 32'h11);
        // Release A: A loads 0x33 while draining 0x11, B drains 0x22 too.
        u_if.in_sel  = 1'b1;
        u_if.in_data = 8'h33;
        u_if.a_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 32'(u_if.in_ready), 32'd1);
        step();
        check("bp_a_second_data",  32'(u_if.a_data),  32'h33);
        check("bp_a_second_valid", 32'(u_if.a_valid), 32'd1);
        check("bp_a_count_dual",   32'(u_if.a_count), 32'd2);
        check("bp_b_count_dual",   32'(u_if.b_count), 32'd2);
        check("bp_b_empty",        32'(u_if.b_valid), 32'd0);
        u_if.in_valid = 1'b0;
        step();
        check("bp_a_count_final", 32'(u_if.a_count), 32'd3);
        check("bp_a_empty",       32'(u_if.a_valid), 32'd0);

        // ---------------- streaming 256 words to A ----------------
        bad_ready     = 0;
        bad_data      = 0;
        u_if.in_sel   = 1'b1;
        u_if.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            u_if.in_data = 8'(i);
            #1;
            if (u_if.in_ready !== 1'b1) bad_ready++;
            step();
            if (u_if.a_valid !== 1'b1 || u_if.a_data !== 8'(i)) bad_data++;
        end
        u_if.in_valid = 1'b0;
        step();
        check("stream_in_ready_stalls", 32'(bad_ready), 32'd0);
        check("stream_order_errors",    32'(bad_data),  32'd0);
        check("stream_a_count",         32'(u_if.a_count), 32'd259);
        check("stream_a_empty",         32'(u_if.a_valid), 32'd0);

        // ---------------- mid-operation reset ----------------
        u_if.a_ready  = 1'b0;
        u_if.b_ready  = 1'b0;
        u_if.in_sel   = 1'b1;
        u_if.in_data  = 8'h5A;
        u_if.in_valid = 1'b1;
        step();
        u_if.in_sel  = 1'b0;
        u_if.in_data = 8'hC3;
        step();
        u_if.in_valid = 1'b0;
        check("mid_a_full", 32'(u_if.a_valid), 32'd1);
        check("mid_b_full", 32'(u_if.b_valid), 32'd1);
        u_if.a_ready = 1'b1;
        u_if.b_ready = 1'b1;
        rst          = 1'b1;
        step();
        rst = 1'b0;
        check("mid_a_valid", 32'(u_if.a_valid), 32'd0);
        check("mid_b_valid", 32'(u_if.b_valid), 32'd0);
        check("mid_a_data",  32'(u_if.a_data),  32'h00);
        check("mid_a_count", 32'(u_if.a_count), 32'd0);
        check("mid_b_count", 32'(u_if.b_count), 32'd0);
        step();
        check("mid_a_count_after", 32'(u_if.a_count), 32'd0);
        check("mid_b_count_after", 32'(u_if.b_count), 32'd0);

        // ---------------- counter wrap, CNT_WIDTH=4 ----------------
        // The word loaded at edge e drains at edge e+1, so after edge e
        // (of 17 loading edges plus one idle edge) the count is e-1.
        w_if.in_sel   = 1'b1;
        w_if.in_valid = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            w_if.in_data = 8'(e);
            if (e == 18) w_if.in_valid = 1'b0;
            step();
            if (e == 16) check("wrap_after_15", 32'(w_if.a_count), 32'd15);
            if (e == 17) check("wrap_after_16", 32'(w_if.a_count), 32'd0);
            if (e == 18) check("wrap_after_17", 32'(w_if.a_count), 32'd1);
        end
        check("wrap_b_count", 32'(w_if.b_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
